// File: rtl/dcmctrl_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : dcmctrl_spi_master
// Brief    : SPI initiator for the dcmctrl register interface. Byte stream in
//            over valid/ready, one response byte per transferred byte.
// Revision : 1.0 - initial release
// ============================================================================
module dcmctrl_spi_master #(
    parameter int CLKDIV   = 5,
    parameter int SS_SETUP = 5,
    parameter int SS_HOLD  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic       cmd_last,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       spi_ss,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam int c_MAX_A = (CLKDIV > SS_SETUP) ? CLKDIV : SS_SETUP;
    localparam int c_MAX   = (c_MAX_A > SS_HOLD) ? c_MAX_A : SS_HOLD;
    localparam int c_CNT_W = $clog2(c_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_DIV   = c_CNT_W'(CLKDIV);
    localparam logic [c_CNT_W-1:0] c_SETUP = c_CNT_W'(SS_SETUP);
    localparam logic [c_CNT_W-1:0] c_HOLD  = c_CNT_W'(SS_HOLD);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t               r_state, w_state;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt;
    logic [2:0]           r_bit, w_bit;
    logic                 r_phase, w_phase;
    logic [7:0]           r_tx, w_tx;
    logic [7:0]           r_rx, w_rx;
    logic                 r_last, w_last;
    logic                 r_ready, w_ready;
    logic                 r_rsp_valid, w_rsp_valid;
    logic [7:0]           r_rsp_data, w_rsp_data;
    logic                 r_busy;
    logic                 r_ss, w_ss;
    logic                 r_sclk, w_sclk;
    logic                 r_mosi, w_mosi;
    logic                 w_load;
    logic [7:0]           w_load_byte;
    logic                 w_accept;
    logic                 w_cnt_done;

    assign w_accept   = cmd_valid & r_ready;
    assign w_cnt_done = (r_cnt == c_ONE);

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_bit       = r_bit;
        w_phase     = r_phase;
        w_tx        = r_tx;
        w_rx        = r_rx;
        w_last      = r_last;
        w_ready     = r_ready;
        w_rsp_valid = 1'b0;
        w_rsp_data  = r_rsp_data;
        w_ss        = r_ss;
        w_sclk      = r_sclk;
        w_mosi      = r_mosi;
        w_load      = 1'b0;
        w_load_byte = r_tx;

        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                w_ss    = 1'b1;
                w_sclk  = 1'b1;
                w_mosi  = 1'b0;
                if (w_accept) begin
                    w_tx    = cmd_data;
                    w_last  = cmd_last;
                    w_ready = 1'b0;
                    w_ss    = 1'b0;
                    w_cnt   = c_SETUP;
                    w_state = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_cnt_done) w_load = 1'b1;
                else            w_cnt  = r_cnt - c_ONE;
            end
            S_SHIFT: begin
                if (!w_cnt_done) begin
                    w_cnt = r_cnt - c_ONE;
                end else if (!r_phase) begin
                    // Rising edge: slave data has been stable since the previous fall.
                    w_sclk  = 1'b1;
                    w_rx    = {r_rx[6:0], spi_miso};
                    w_phase = 1'b1;
                    w_cnt   = c_DIV;
                end else if (r_bit == 3'd0) begin
                    w_rsp_valid = 1'b1;
                    w_rsp_data  = r_rx;
                    if (r_last) begin
                        w_cnt   = c_HOLD;
                        w_state = S_HOLD;
                    end else begin
                        w_ready = 1'b1;
                        w_state = S_WAIT;
                    end
                end else begin
                    w_bit   = r_bit - 3'd1;
                    w_sclk  = 1'b0;
                    w_mosi  = r_tx[7];
                    w_tx    = {r_tx[6:0], 1'b0};
                    w_phase = 1'b0;
                    w_cnt   = c_DIV;
                end
            end
            S_WAIT: begin
                w_ss    = 1'b0;
                w_sclk  = 1'b1;
                w_ready = 1'b1;
                if (w_accept) begin
                    w_ready     = 1'b0;
                    w_last      = cmd_last;
                    w_load      = 1'b1;
                    w_load_byte = cmd_data;
                end
            end
            S_HOLD: begin
                if (w_cnt_done) begin
                    w_ss    = 1'b1;
                    w_mosi  = 1'b0;
                    w_cnt   = c_HOLD;
                    w_state = S_GAP;
                end else begin
                    w_cnt = r_cnt - c_ONE;
                end
            end
            S_GAP: begin
                if (w_cnt_done) begin
                    w_ready = 1'b1;
                    w_state = S_IDLE;
                end else begin
                    w_cnt = r_cnt - c_ONE;
                end
            end
            default: w_state = S_IDLE;
        endcase

        // First falling edge of a byte: present the MSB and clear the receiver.
        if (w_load) begin
            w_state = S_SHIFT;
            w_bit   = 3'd7;
            w_phase = 1'b0;
            w_sclk  = 1'b0;
            w_mosi  = w_load_byte[7];
            w_tx    = {w_load_byte[6:0], 1'b0};
            w_rx    = 8'h00;
            w_cnt   = c_DIV;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= 3'd7;
            r_phase     <= 1'b0;
            r_tx        <= 8'h00;
            r_rx        <= 8'h00;
            r_last      <= 1'b0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
            r_busy      <= 1'b0;
            r_ss        <= 1'b1;
            r_sclk      <= 1'b1;
            r_mosi      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_bit       <= w_bit;
            r_phase     <= w_phase;
            r_tx        <= w_tx;
            r_rx        <= w_rx;
            r_last      <= w_last;
            r_ready     <= w_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_data  <= w_rsp_data;
            r_busy      <= (w_state != S_IDLE);
            r_ss        <= w_ss;
            r_sclk      <= w_sclk;
            r_mosi      <= w_mosi;
        end
    end

    assign cmd_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_busy;
    assign spi_ss    = r_ss;
    assign spi_clk   = r_sclk;
    assign spi_mosi  = r_mosi;

endmodule
`default_nettype wire
